// File: rtl/ring_pkg.sv
// Shared types and helpers for the one-hot ring counter monitor.
package ring_pkg;
  localparam int RING_WIDTH     = 4;
  localparam int RING_ERR_LIMIT = 3;
  localparam int RING_CNT_W     = 8;
  localparam int RING_MAX_W     = 32;

  typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED, FAULT} ring_state_e;

  // Expected successor of vec when only its low w bits are meaningful.
  function automatic logic [RING_MAX_W-1:0] rot_right(input logic [RING_MAX_W-1:0] vec,
                                                      input int w);
    return (vec >> 1) | ({{(RING_MAX_W-1){1'b0}}, vec[0]} << (w - 1));
  endfunction
endpackage

// File: rtl/ring_onehot_check.sv
// Combinational one-hot / rotation check of the current ring sample against the previous one.
module ring_onehot_check
  import ring_pkg::*;
#(
  parameter int WIDTH = RING_WIDTH
) (
  input  logic [WIDTH-1:0]         q_in,
  input  logic [WIDTH-1:0]         prev,
  output logic                     valid,
  output logic                     good,
  output logic                     wrap,
  output logic [$clog2(WIDTH)-1:0] idx
);
  localparam int IW = $clog2(WIDTH);

  logic [RING_MAX_W-1:0] expected;

  assign expected = rot_right(RING_MAX_W'(prev), WIDTH);
  assign valid    = ($countones(q_in) == 1);
  assign good     = valid && (RING_MAX_W'(q_in) == expected);
  assign wrap     = prev[0] && q_in[WIDTH-1];

  // OR of the indices of all set bits: exact for a valid sample, no priority chain.
  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++)
      if (q_in[i]) idx = idx | IW'(i);
  end
endmodule

// File: rtl/ring_monitor.sv
// Ring counter health checker / phase decoder; every output registered, 1-cycle latency.
// Define RING_MON_STATS_EN to implement rev_count/err_count; otherwise both read constant 0.
module ring_monitor
  import ring_pkg::*;
#(
  parameter int WIDTH     = RING_WIDTH,
  parameter int ERR_LIMIT = RING_ERR_LIMIT,
  parameter int CNT_W     = RING_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [WIDTH-1:0]         q_in,
  input  logic                     clear_fault,
  output logic                     locked,
  output logic                     fault,
  output logic [$clog2(WIDTH)-1:0] phase_idx,
  output logic                     rev_tick,
  output logic                     err_pulse,
  output logic [CNT_W-1:0]         rev_count,
  output logic [CNT_W-1:0]         err_count
);
  localparam int IW    = $clog2(WIDTH);
  localparam int RUN_W = $clog2(WIDTH + 1);
  localparam int BAD_W = $clog2(ERR_LIMIT + 1);

  ring_state_e      state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d, run_inc;
  logic [BAD_W-1:0] bad_q, bad_d, bad_inc;
  logic [WIDTH-1:0] prev_q;
  logic [IW-1:0]    phase_q, idx;
  logic             valid, good, wrap;
  logic             upd_prev, tick_d, errp_d, tick_q, errp_q;

  ring_onehot_check #(.WIDTH(WIDTH)) u_check (
    .q_in  (q_in),
    .prev  (prev_q),
    .valid (valid),
    .good  (good),
    .wrap  (wrap),
    .idx   (idx)
  );

  assign run_inc = run_q + 1'b1;
  assign bad_inc = bad_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    run_d    = run_q;
    bad_d    = bad_q;
    tick_d   = 1'b0;
    errp_d   = 1'b0;
    upd_prev = 1'b0;
    if (en) begin
      upd_prev = valid && (state_q != FAULT);
      case (state_q)
        UNLOCKED: begin
          if (valid) begin
            state_d = ACQUIRE;
            run_d   = '0;
          end
        end
        ACQUIRE: begin
          if (!valid) begin
            state_d = UNLOCKED;
          end else if (good) begin
            run_d = run_inc;
            if (run_inc == RUN_W'(WIDTH)) begin
              state_d = LOCKED;
              bad_d   = '0;
              tick_d  = wrap;
            end
          end else begin
            run_d = '0;
          end
        end
        LOCKED: begin
          if (good) begin
            bad_d  = '0;
            tick_d = wrap;
          end else begin
            errp_d = 1'b1;
            bad_d  = bad_inc;
            if (bad_inc == BAD_W'(ERR_LIMIT)) state_d = FAULT;
          end
        end
        FAULT: begin
          if (clear_fault) state_d = UNLOCKED;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= UNLOCKED;
      run_q   <= '0;
      bad_q   <= '0;
      prev_q  <= '0;
      phase_q <= '0;
      tick_q  <= 1'b0;
      errp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      bad_q   <= bad_d;
      tick_q  <= tick_d;
      errp_q  <= errp_d;
      if (upd_prev) begin
        prev_q  <= q_in;
        phase_q <= idx;
      end
    end
  end

  assign locked    = (state_q == LOCKED);
  assign fault     = (state_q == FAULT);
  assign phase_idx = phase_q;
  assign rev_tick  = tick_q;
  assign err_pulse = errp_q;

`ifdef RING_MON_STATS_EN
  logic [CNT_W-1:0] rev_q, errc_q;

  // Saturating counters: they stick at all-ones rather than wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rev_q  <= '0;
      errc_q <= '0;
    end else begin
      if (tick_d && (rev_q != '1)) rev_q <= rev_q + 1'b1;
      if (errp_d && (errc_q != '1)) errc_q <= errc_q + 1'b1;
    end
  end

  assign rev_count = rev_q;
  assign err_count = errc_q;
`else
  assign rev_count = '0;
  assign err_count = '0;
`endif
endmodule

// File: tb/tb_ring_monitor.sv
// Self-checking bench for ring_monitor: directed table, corner sequences and a randomized run against a reference model.
module tb_ring_monitor;
  localparam int W    = 4;
  localparam int LIM  = 3;
  localparam int CW   = 8;
  localparam int CMAX = 255;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [W-1:0]  q_in = '0;
  logic          clear_fault = 1'b0;
  logic          locked, fault, rev_tick, err_pulse;
  logic [1:0]    phase_idx;
  logic [CW-1:0] rev_count, err_count;

  ring_monitor #(.WIDTH(W), .ERR_LIMIT(LIM), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .q_in        (q_in),
    .clear_fault (clear_fault),
    .locked      (locked),
    .fault       (fault),
    .phase_idx   (phase_idx),
    .rev_tick    (rev_tick),
    .err_pulse   (err_pulse),
    .rev_count   (rev_count),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: 0 unlocked, 1 acquiring, 2 locked, 3 fault.
  int           m_st, m_run, m_bad, m_rev, m_err, m_phase;
  bit           m_tick, m_errp;
  logic [W-1:0] m_prev;
  logic [W-1:0] ring;

  typedef struct {
    logic         en;
    logic [W-1:0] q;
    logic         clr;
    logic         lk;
    logic         ft;
    int           ph;
    logic         tk;
    logic         ep;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
  endtask

  function automatic int ones(input logic [W-1:0] v);
    int n = 0;
    for (int i = 0; i < W; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic int hot(input logic [W-1:0] v);
    for (int i = 0; i < W; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [W-1:0] rot();
    ring = {ring[0], ring[W-1:1]};
    return ring;
  endfunction

  task automatic model_step(input logic e, input logic [W-1:0] q, input logic c);
    bit v, g, wr;
    m_tick = 0;
    m_errp = 0;
    if (!e) return;
    if (m_st == 3) begin
      if (c) m_st = 0;
      return;
    end
    v  = (ones(q) == 1);
    // Right rotation moves the hot bit one index lower, W-1 following 0.
    g  = v && (hot(m_prev) >= 0) && (hot(q) == (hot(m_prev) + W - 1) % W);
    wr = g && (hot(m_prev) == 0);
    case (m_st)
      0: if (v) begin m_st = 1; m_run = 0; end
      1: begin
        if (!v) m_st = 0;
        else if (g) begin
          m_run++;
          if (m_run == W) begin m_st = 2; m_bad = 0; m_tick = wr; end
        end else m_run = 0;
      end
      default: begin
        if (g) begin m_bad = 0; m_tick = wr; end
        else begin
          m_errp = 1;
          m_bad++;
          if (m_bad == LIM) m_st = 3;
        end
      end
    endcase
    if (v) begin m_prev = q; m_phase = hot(q); end
    if (m_tick && m_rev < CMAX) m_rev++;
    if (m_errp && m_err < CMAX) m_err++;
  endtask

  task automatic compare_all();
    int er, ee;
`ifdef RING_MON_STATS_EN
    er = m_rev;
    ee = m_err;
`else
    er = 0;
    ee = 0;
`endif
    chk("locked", int'(locked), int'(m_st == 2));
    chk("fault", int'(fault), int'(m_st == 3));
    chk("phase_idx", int'(phase_idx), m_phase);
    chk("rev_tick", int'(rev_tick), int'(m_tick));
    chk("err_pulse", int'(err_pulse), int'(m_errp));
    chk("rev_count", int'(rev_count), er);
    chk("err_count", int'(err_count), ee);
  endtask

  task automatic step(input logic e, input logic [W-1:0] q, input logic c);
    en = e;
    q_in = q;
    clear_fault = c;
    @(posedge clk);
    #1;
    model_step(e, q, c);
    compare_all();
  endtask

  task automatic do_reset(input logic e, input logic [W-1:0] q, input logic c);
    rst_n = 1'b0;
    en = e;
    q_in = q;
    clear_fault = c;
    @(posedge clk);
    #1;
    m_st = 0; m_run = 0; m_bad = 0; m_rev = 0; m_err = 0; m_phase = 0;
    m_tick = 0; m_errp = 0; m_prev = '0;
    compare_all();
    rst_n = 1'b1;
  endtask

  task automatic run_table();
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].en, tbl[i].q, tbl[i].clr);
      chk($sformatf("tbl%0d_locked", i), int'(locked), int'(tbl[i].lk));
      chk($sformatf("tbl%0d_fault", i), int'(fault), int'(tbl[i].ft));
      chk($sformatf("tbl%0d_phase", i), int'(phase_idx), tbl[i].ph);
      chk($sformatf("tbl%0d_tick", i), int'(rev_tick), int'(tbl[i].tk));
      chk($sformatf("tbl%0d_err", i), int'(err_pulse), int'(tbl[i].ep));
    end
    ring = 4'b1000;
  endtask

  initial begin
    int exp_sat;
    // Clean ring from 1000: lock on the 5th sample (a wrap), then a single invalid 0110.
    tbl[0]  = '{1'b1, 4'b1000, 1'b0, 1'b0, 1'b0, 3, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 2, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 4'b1000, 1'b0, 1'b1, 1'b0, 3, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 4'b0100, 1'b0, 1'b1, 1'b0, 2, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 4'b0010, 1'b1, 1'b1, 1'b0, 1, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 4'b0001, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 4'b1000, 1'b0, 1'b1, 1'b0, 3, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 4'b0110, 1'b0, 1'b1, 1'b0, 3, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 4'b0100, 1'b0, 1'b1, 1'b0, 2, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 4'b0010, 1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 4'b0001, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 4'b1000, 1'b0, 1'b1, 1'b0, 3, 1'b1, 1'b0};
`ifdef RING_MON_STATS_EN
    exp_sat = CMAX;
`else
    exp_sat = 0;
`endif
    ring = 4'b1000;

    do_reset(1'b1, 4'b1000, 1'b1);
    run_table();

    // Three consecutive empty samples while locked force FAULT.
    for (int i = 0; i < LIM; i++) step(1'b1, 4'b0000, 1'b0);
    chk("fault_at_limit", int'(fault), 1);
    chk("unlocked_at_limit", int'(locked), 0);
    for (int i = 0; i < 6; i++) step(1'b1, rot(), 1'b0);
    chk("fault_sticky", int'(fault), 1);
    step(1'b1, rot(), 1'b1);
    chk("fault_cleared", int'(fault), 0);
    for (int i = 0; i < 5; i++) step(1'b1, rot(), 1'b0);
    chk("relock_5", int'(locked), 1);

    // Disabled window while the ring keeps turning; prev goes stale.
    for (int i = 0; i < 3; i++) step(1'b1, rot(), 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, rot(), 1'b0);
    chk("en0_hold_locked", int'(locked), 1);
    step(1'b1, rot(), 1'b0);
    chk("stale_prev_err", int'(err_pulse), 1);
    for (int i = 0; i < 2; i++) step(1'b1, rot(), 1'b0);
    chk("resync_no_err", int'(err_pulse), 0);

    // Revolution counter saturation.
    for (int i = 0; i < 260 * W; i++) step(1'b1, rot(), 1'b0);
    chk("rev_saturated", int'(rev_count), exp_sat);

    // Reset wins over clear_fault while in FAULT.
    for (int i = 0; i < LIM; i++) step(1'b1, 4'b0000, 1'b0);
    chk("fault_before_rst", int'(fault), 1);
    do_reset(1'b1, rot(), 1'b1);
    chk("rst_fault", int'(fault), 0);
    chk("rst_phase", int'(phase_idx), 0);
    step(1'b0, 4'b0000, 1'b0);
    chk("rst_unlocked", int'(locked), 0);
    ring = 4'b1000;
    run_table();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic e, c;
      logic [W-1:0] q;
      int mode;
      e = ($urandom_range(0, 9) != 0);
      c = ($urandom_range(0, 9) == 0);
      mode = $urandom_range(0, 9);
      if (mode <= 6) q = rot();
      else if (mode == 7) q = 4'($urandom_range(0, 15));
      else if (mode == 8) q = '0;
      else q = 4'(1 << $urandom_range(0, W - 1));
      if ($urandom_range(0, 199) == 0) do_reset(e, q, c);
      else step(e, q, c);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
